vga_timing_monitor: RTL and testbench

- Receive-side counterpart of the VGA generator.
- Taps the generator's VGA output bus in the same 50 MHz domain and recovers the pixel clock, line and frame boundaries.
- Measures active width, active height, hsync width and frame count, and captures the RGB value at a software-chosen pixel.
- Exposes all results to the HPS through an Avalon-MM slave with read support, for bring-up and self-check of the display path.

---
 rtl/vga_timing_monitor.sv | 193 +++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: recovers pixel/line/frame timing from the VGA bus and exposes measurements over Avalon-MM.
// Optional CRC-16-CCITT over active pixels is built when VGA_MON_CRC_EN is defined.
module vga_timing_monitor #(
  parameter int H_EXPECT = 640,
  parameter int V_EXPECT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_n,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B
);

  logic        vclk_q;
  logic        pix;
  logic        hs_q, vs_q, blank_q;
  logic        hs_fall, hs_rise, vs_fall;
  logic [10:0] x_cnt, y_cnt, hs_len;
  logic        line_active, frame_ok;
  logic [10:0] width_reg, height_reg, hsync_reg;
  logic [15:0] frame_cnt;
  logic        locked, err_sticky;
  logic [9:0]  probe_x, probe_y;
  logic [23:0] rgb_reg;
  logic        cap_valid;
  logic        wr, rd;
  logic [3:0]  sel;
  logic        line_err, capture;
  logic [31:0] rd_mux;
  logic [31:0] crc_word;
  logic        unused_bits;

  assign pix     = VGA_CLK & ~vclk_q;
  assign hs_fall = pix & hs_q & ~VGA_HS;
  assign hs_rise = pix & ~hs_q & VGA_HS;
  assign vs_fall = pix & vs_q & ~VGA_VS;

  assign wr  = chipselect & write;
  assign rd  = chipselect & read;
  assign sel = address[3:0];

  assign line_err = hs_fall & line_active & (x_cnt != 11'(H_EXPECT));
  // x_cnt is compared before this pixel's increment, so pixel 0 matches probe_x=0
  assign capture  = pix & VGA_BLANK_n & (x_cnt == {1'b0, probe_x}) & (y_cnt == {1'b0, probe_y});

  assign unused_bits = ^{address[15:4], writedata[31:10], blank_q};

  // Pixel-domain timing recovery
  always_ff @(posedge clk) begin
    if (reset) begin
      vclk_q      <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b1;
      x_cnt       <= '0;
      y_cnt       <= '0;
      hs_len      <= '0;
      line_active <= 1'b0;
      frame_ok    <= 1'b1;
      width_reg   <= '0;
      height_reg  <= '0;
      hsync_reg   <= '0;
      locked      <= 1'b0;
    end else begin
      vclk_q <= VGA_CLK;
      if (pix) begin
        hs_q    <= VGA_HS;
        vs_q    <= VGA_VS;
        blank_q <= VGA_BLANK_n;
        if (hs_fall) begin
          x_cnt       <= '0;
          line_active <= 1'b0;
        end else if (VGA_BLANK_n) begin
          x_cnt       <= x_cnt + 11'd1;
          line_active <= 1'b1;
        end
        if (hs_rise) begin
          hsync_reg <= hs_len;
          hs_len    <= '0;
        end else if (!VGA_HS) begin
          hs_len <= hs_len + 11'd1;
        end
      end
      if (hs_fall && line_active) begin
        width_reg <= x_cnt;
        y_cnt     <= y_cnt + 11'd1;
      end
      if (line_err)
        frame_ok <= 1'b0;
      // Frame boundary: publish height and lock state, restart line accounting
      if (vs_fall) begin
        height_reg <= y_cnt;
        locked     <= frame_ok & (y_cnt == 11'(V_EXPECT));
        y_cnt      <= '0;
        frame_ok   <= 1'b1;
      end
    end
  end

  // Software-visible state: probe, capture, frame counter, error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      probe_x    <= '0;
      probe_y    <= '0;
      rgb_reg    <= '0;
      cap_valid  <= 1'b0;
      frame_cnt  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (wr && sel == 4'd0) probe_x <= writedata[9:0];
      if (wr && sel == 4'd1) probe_y <= writedata[9:0];
      if (capture) begin
        rgb_reg   <= {VGA_R, VGA_G, VGA_B};
        cap_valid <= 1'b1;
      end else if (rd && sel == 4'd2) begin
        cap_valid <= 1'b0;
      end
      if (wr && sel == 4'd6)
        frame_cnt <= '0;
      else if (vs_fall)
        frame_cnt <= frame_cnt + 16'd1;
      if (line_err)
        err_sticky <= 1'b1;
      else if (wr && sel == 4'd7 && writedata[1])
        err_sticky <= 1'b0;
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_run, crc_reg;

  function automatic logic [15:0] crc16_24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_run <= 16'hFFFF;
      crc_reg <= '0;
    end else if (vs_fall) begin
      crc_reg <= crc_run;
      crc_run <= 16'hFFFF;
    end else if (pix && VGA_BLANK_n) begin
      crc_run <= crc16_24(crc_run, {VGA_R, VGA_G, VGA_B});
    end
  end

  assign crc_word = {16'b0, crc_reg};
`else
  assign crc_word = 32'b0;
`endif

  always_comb begin
    rd_mux = 32'b0;
    case (sel)
      4'd0: rd_mux = {22'b0, probe_x};
      4'd1: rd_mux = {22'b0, probe_y};
      4'd2: rd_mux = {7'b0, cap_valid, rgb_reg};
      4'd3: rd_mux = {21'b0, width_reg};
      4'd4: rd_mux = {21'b0, height_reg};
      4'd5: rd_mux = {21'b0, hsync_reg};
      4'd6: rd_mux = {16'b0, frame_cnt};
      4'd7: rd_mux = {30'b0, err_sticky, locked};
      4'd8: rd_mux = crc_word;
      default: rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else if (rd)
      readdata <= rd_mux;
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a miniature VGA raster (8x4 active) so frames stay short.
// Covers measurements, probe capture, error/lock handling, counter clear, reset mid-frame and the CRC register.
module tb_vga_timing_monitor;
  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2, HT = HA + HFP + HSW + HBP;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1, VT = VA + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [15:0] address;
  logic [31:0] writedata, readdata;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int checks = 0;
  int failures = 0;
  logic [31:0] crc_exp;

  vga_timing_monitor #(.H_EXPECT(HA), .V_EXPECT(VA)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    chipselect = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
  endtask

  task automatic idle_video();
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
    VGA_R = '0; VGA_G = '0; VGA_B = '0;
  endtask

  task automatic rchk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    idle_bus();
    chk(tag, readdata, exp);
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    idle_bus();
  endtask

  // One pixel: low half then high half of VGA_CLK; the monitor samples on the rising half.
  task automatic put_pixel(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb,
                           input logic wr6);
    @(negedge clk);
    idle_bus();
    VGA_CLK = 1'b0; VGA_HS = hs; VGA_VS = vs; VGA_BLANK_n = bl;
    {VGA_R, VGA_G, VGA_B} = rgb;
    @(negedge clk);
    VGA_CLK = 1'b1;
    if (wr6) begin
      chipselect = 1'b1; write = 1'b1; address = 16'd6; writedata = 32'd0;
    end
  endtask

  task automatic frame(input int start_line, input int stop_line, input int bad_line,
                       input logic const_col, input logic wr6);
    logic hs, vs, bl, w;
    logic [23:0] rgb;
    for (int ln = start_line; ln < VT; ln++) begin
      for (int x = 0; x < HT; x++) begin
        if (ln == stop_line && x == HA / 2) begin
          @(negedge clk);
          idle_bus();
          idle_video();
          return;
        end
        bl  = (ln < VA) && (x < ((ln == bad_line) ? HA - 1 : HA));
        hs  = !((x >= HA + HFP) && (x < HA + HFP + HSW));
        vs  = !((ln >= VA + VFP) && (ln < VA + VFP + VSW));
        rgb = const_col ? 24'h123456 : {8'(x + 16), 8'(ln + 32), 8'h5A};
        w   = wr6 && (ln == VA + VFP) && (x == 0);
        put_pixel(hs, vs, bl, rgb, w);
      end
    end
    @(negedge clk);
    idle_bus();
    idle_video();
  endtask

  function automatic logic [15:0] crc_ref(input int npix, input logic [23:0] d);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int p = 0; p < npix; p++)
      for (int i = 23; i >= 0; i--) begin
        fb = c[15] ^ d[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  initial begin
    idle_bus();
    idle_video();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 32'h0);
    reset = 1'b0;
    rchk("reset_width", 16'd3, 32'h0);
    rchk("reset_status", 16'd7, 32'h0);

    // Three clean frames with probe at (0,0)
    repeat (3) frame(0, -1, -1, 1'b0, 1'b0);
    rchk("width", 16'd3, 32'd8);
    rchk("height", 16'd4, 32'd4);
    rchk("hsync", 16'd5, 32'd3);
    rchk("frames3", 16'd6, 32'd3);
    rchk("locked", 16'd7, 32'h1);
    rchk("probe00", 16'd2, 32'h0110205A);
    rchk("probe00_reread", 16'd2, 32'h0010205A);

    // Last active pixel, then mid-frame pixel
    wr_reg(16'd0, 32'd7);
    wr_reg(16'd1, 32'd3);
    rchk("probe_x_rb", 16'd0, 32'd7);
    rchk("probe_y_rb", 16'd1, 32'd3);
    frame(0, -1, -1, 1'b0, 1'b0);
    rchk("probe73", 16'd2, 32'h0117235A);
    wr_reg(16'd0, 32'hFFFF_FC05);
    wr_reg(16'd1, 32'd2);
    rchk("probe_x_mask", 16'd0, 32'd5);
    frame(0, -1, -1, 1'b0, 1'b0);
    rchk("probe52", 16'd2, 32'h0115225A);
    // x=8 is never active, so nothing is captured
    wr_reg(16'd0, 32'd8);
    wr_reg(16'd1, 32'd0);
    frame(0, -1, -1, 1'b0, 1'b0);
    rchk("probe_oob", 16'd2, 32'h0015225A);

    // Short line sets the sticky error and drops lock
    frame(0, -1, 2, 1'b0, 1'b0);
    rchk("bad_status", 16'd7, 32'h2);
    rchk("bad_width_last", 16'd3, 32'd8);
    wr_reg(16'd7, 32'h2);
    rchk("err_cleared", 16'd7, 32'h0);
    frame(0, -1, -1, 1'b0, 1'b0);
    rchk("relocked", 16'd7, 32'h1);
    rchk("frames8", 16'd6, 32'd8);
    wr_reg(16'd3, 32'h55);
    rchk("ro_write", 16'd3, 32'd8);

    // Counter clear coincident with VS falling edge
    frame(0, -1, -1, 1'b0, 1'b1);
    rchk("clr_vs_same", 16'd6, 32'd0);
    frame(0, -1, -1, 1'b0, 1'b0);
    rchk("count_after_clr", 16'd6, 32'd1);

    // CRC over a constant-colour frame
    frame(0, -1, -1, 1'b1, 1'b0);
`ifdef VGA_MON_CRC_EN
    crc_exp = {16'b0, crc_ref(HA * VA, 24'h123456)};
`else
    crc_exp = 32'h0;
`endif
    rchk("crc", 16'd8, crc_exp);
    rchk("addr9", 16'd9, 32'h0);
    rchk("alias_13", 16'h0013, 32'd8);

    // Reset mid-line
    frame(0, 1, -1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_readdata", readdata, 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 9; a++) rchk($sformatf("rst_mid_addr%0d", a), 16'(a), 32'h0);
    frame(2, -1, -1, 1'b0, 1'b0);
    rchk("partial_height", 16'd4, 32'd2);
    rchk("partial_status", 16'd7, 32'h0);
    rchk("partial_frames", 16'd6, 32'd1);
    frame(0, -1, -1, 1'b0, 1'b0);
    rchk("post_rst_status", 16'd7, 32'h1);
    rchk("post_rst_height", 16'd4, 32'd4);
    rchk("post_rst_frames", 16'd6, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
